// File: rtl/lru_access_ctrl_pkg.sv
// Shared types and constants for the LRU access stage, tag bank, LRU table and next-state logic.
package lru_access_ctrl_pkg;

    localparam int ADDR_W    = 16;
    localparam int IDX_W     = 7;
    localparam int TAG_W     = ADDR_W - IDX_W;
    localparam int WAY_W     = 2;
    localparam int NUM_WAYS  = 4;
    localparam int NUM_LINES = 1 << IDX_W;

    typedef logic [WAY_W-1:0]  way_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MEMREQ  = 3'd2,
        S_MEMWAIT = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    function automatic way_t first_invalid(input logic [NUM_WAYS-1:0] valid);
        way_t w;
        w = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) w = way_t'(i);
        end
        return w;
    endfunction

endpackage

// File: rtl/lru_access_ctrl_if.sv
// CPU request/response, refill handshake and LRU table signals of the access stage.
interface lru_access_ctrl_if;
    import lru_access_ctrl_pkg::*;

    logic  req_valid;
    logic  req_ready;
    addr_t req_addr;
    logic  resp_valid;
    logic  resp_hit;
    way_t  resp_way;
    logic  mem_req_valid;
    logic  mem_req_ready;
    addr_t mem_req_addr;
    logic  mem_ack;
    idx_t  lru_line;
    way_t  lru_victim;
    logic  lru_upd;
    way_t  lru_way;

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_ack, lru_victim,
        input  req_ready, resp_valid, resp_hit, resp_way, mem_req_valid,
               mem_req_addr, lru_line, lru_upd, lru_way
    );

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_ack, lru_victim,
        output req_ready, resp_valid, resp_hit, resp_way, mem_req_valid,
               mem_req_addr, lru_line, lru_upd, lru_way
    );

endinterface

// File: rtl/lru_access_ctrl_tag_bank.sv
// 4-way tag + valid store with one write port, combinational compare and victim choice.
// LRU_INVALID_FIRST_EN: prefer the lowest invalid way over the table's LRU way on a miss.
module lru_tag_bank
    import lru_access_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  idx_t rd_line_i,
    input  tag_t rd_tag_i,
    input  way_t lru_victim_i,
    output logic hit_o,
    output way_t hit_way_o,
    output way_t victim_o,
    input  logic wr_en_i,
    input  idx_t wr_line_i,
    input  way_t wr_way_i,
    input  tag_t wr_tag_i
);

    tag_t                tag_q   [NUM_LINES][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_LINES];
    logic [NUM_WAYS-1:0] line_valid;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int l = 0; l < NUM_LINES; l++) valid_q[l] <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_line_i][wr_way_i] <= 1'b1;
        end
    end

    // Tags are deliberately left unreset; the valid bits gate every compare.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) tag_q[wr_line_i][wr_way_i] <= wr_tag_i;
    end

    assign line_valid = valid_q[rd_line_i];

    always_comb begin
        hit_o     = 1'b0;
        hit_way_o = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (line_valid[w] && (tag_q[rd_line_i][w] == rd_tag_i)) begin
                hit_o     = 1'b1;
                hit_way_o = way_t'(w);
            end
        end
    end

`ifdef LRU_INVALID_FIRST_EN
    assign victim_o = (&line_valid) ? lru_victim_i : first_invalid(line_valid);
`else
    assign victim_o = lru_victim_i;
`endif

endmodule

// File: rtl/lru_access_ctrl.sv
// Access stage for the LRU predictor table: lookup, miss/refill FSM, LRU update strobes.
// Victim policy selectable via LRU_INVALID_FIRST_EN (see lru_tag_bank).
module lru_access_ctrl
    import lru_access_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    lru_access_ctrl_if.slave  bus
);

    // state     | meaning
    // S_IDLE    | ready for a request
    // S_LOOKUP  | compare tag, pick hit way or victim
    // S_MEMREQ  | refill request held until accepted
    // S_MEMWAIT | waiting for refill ack, then write tag
    // S_RESP    | response + LRU update strobe

    state_e state_q, state_d;
    addr_t  addr_q, addr_d;
    idx_t   line_q, line_d;
    way_t   way_q, way_d;
    logic   hit_q, hit_d;
    logic   bank_hit;
    way_t   bank_way;
    way_t   victim;
    logic   wr_en;

    lru_tag_bank u_tag_bank (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .rd_line_i    (line_q),
        .rd_tag_i     (addr_q[ADDR_W-1:IDX_W]),
        .lru_victim_i (bus.lru_victim),
        .hit_o        (bank_hit),
        .hit_way_o    (bank_way),
        .victim_o     (victim),
        .wr_en_i      (wr_en),
        .wr_line_i    (line_q),
        .wr_way_i     (way_q),
        .wr_tag_i     (addr_q[ADDR_W-1:IDX_W])
    );

    assign bus.lru_line = line_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            way_q   <= way_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        line_d            = line_q;
        way_d             = way_q;
        hit_d             = hit_q;
        wr_en             = 1'b0;
        bus.req_ready     = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.resp_hit      = 1'b0;
        bus.resp_way      = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.lru_upd       = 1'b0;
        bus.lru_way       = '0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    line_d  = bus.req_addr[IDX_W-1:0];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d   = bank_hit;
                way_d   = bank_hit ? bank_way : victim;
                state_d = bank_hit ? S_RESP : S_MEMREQ;
            end
            S_MEMREQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = addr_q;
                if (bus.mem_req_ready) state_d = S_MEMWAIT;
            end
            S_MEMWAIT: begin
                if (bus.mem_ack) begin
                    wr_en   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_hit   = hit_q;
                bus.resp_way   = way_q;
                bus.lru_upd    = 1'b1;
                bus.lru_way    = way_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lru_access_ctrl.sv
// Randomized bench for lru_access_ctrl against a per-line tag/valid reference model.
module tb_lru_access_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    bit [8:0] m_tag [128][4];
    bit       m_val [128][4];

    lru_access_ctrl_if bus ();

    lru_access_ctrl dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear();
        for (int l = 0; l < 128; l++)
            for (int w = 0; w < 4; w++) m_val[l][w] = 1'b0;
    endtask

    // Expected outcome of one access: hit way, or the way a refill will land in.
    task automatic model_predict(input logic [15:0] a, input logic [1:0] v,
                                 output bit hit, output logic [1:0] way);
        int idx;
        int tg;
        idx = int'(a[6:0]);
        tg  = int'(a[15:7]);
        hit = 1'b0;
        way = v;
        for (int w = 0; w < 4; w++)
            if (m_val[idx][w] && int'(m_tag[idx][w]) == tg) begin
                hit = 1'b1;
                way = 2'(w);
            end
`ifdef LRU_INVALID_FIRST_EN
        if (!hit)
            for (int w = 3; w >= 0; w--)
                if (!m_val[idx][w]) way = 2'(w);
`endif
    endtask

    task automatic check_resp(input bit hit, input logic [1:0] way, input logic [6:0] idx);
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("resp_hit",   32'(bus.resp_hit),   32'(hit));
        chk("resp_way",   32'(bus.resp_way),   32'(way));
        chk("lru_upd",    32'(bus.lru_upd),    32'd1);
        chk("lru_way",    32'(bus.lru_way),    32'(way));
        chk("lru_line",   32'(bus.lru_line),   32'(idx));
    endtask

    task automatic do_req(input logic [15:0] a, input logic [1:0] v,
                          input int rdly, input int adly, input bit stray);
        bit         eh;
        logic [1:0] ew;
        model_predict(a, v, eh, ew);
        @(negedge clk);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_no_resp", 32'(bus.resp_valid), 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.lru_victim = v;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        chk("lookup_ready", 32'(bus.req_ready), 32'd0);
        chk("lookup_no_resp", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        if (eh) begin
            check_resp(1'b1, ew, a[6:0]);
            chk("hit_no_memreq", 32'(bus.mem_req_valid), 32'd0);
        end else begin
            chk("memreq_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("memreq_addr", 32'(bus.mem_req_addr), 32'(a));
            chk("miss_no_resp", 32'(bus.resp_valid), 32'd0);
            for (int i = 0; i < rdly; i++) begin
                bus.mem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                chk("memreq_hold", 32'(bus.mem_req_valid), 32'd1);
                chk("memreq_addr_hold", 32'(bus.mem_req_addr), 32'(a));
                chk("memreq_ready_low", 32'(bus.req_ready), 32'd0);
            end
            bus.mem_req_ready = 1'b1;
            bus.mem_ack       = stray;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.mem_ack       = 1'b0;
            chk("memwait_no_req", 32'(bus.mem_req_valid), 32'd0);
            chk("memwait_no_resp", 32'(bus.resp_valid), 32'd0);
            for (int i = 0; i < adly; i++) begin
                @(negedge clk);
                chk("memwait_idle", 32'(bus.resp_valid), 32'd0);
            end
            bus.mem_ack = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            check_resp(1'b0, ew, a[6:0]);
            m_tag[a[6:0]][ew] = a[15:7];
            m_val[a[6:0]][ew] = 1'b1;
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_ack       = 1'b0;
        bus.lru_victim    = '0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_req_addr", 32'(bus.mem_req_addr), 32'd0);
        chk("rst_lru_upd", 32'(bus.lru_upd), 32'd0);
        chk("rst_lru_line", 32'(bus.lru_line), 32'd0);

        // first miss, then the same address hits
        do_req(16'h0102, 2'd2, 0, 1, 1'b0);
        do_req(16'h0102, 2'd1, 0, 0, 1'b0);

        // fill line 2 with tags 1..4, then tag 5 evicts way 3
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        do_req(16'h0082, 2'd0, 0, 0, 1'b0);
        do_req(16'h0102, 2'd1, 1, 0, 1'b0);
        do_req(16'h0182, 2'd2, 0, 2, 1'b0);
        do_req(16'h0202, 2'd3, 0, 0, 1'b0);
        do_req(16'h0282, 2'd3, 0, 0, 1'b0);
        do_req(16'h0202, 2'd0, 0, 0, 1'b0);

        // refill request stalled 5 cycles with stray acks
        do_req(16'h0305, 2'd1, 5, 3, 1'b1);

        // reset while waiting for the refill ack
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = 16'h0409;
        bus.lru_victim = 2'd0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        reset       = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bus.mem_ack = 1'b0;
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_lru_upd", 32'(bus.lru_upd), 32'd0);
        chk("abort_mem_req", 32'(bus.mem_req_valid), 32'd0);
        model_clear();
        do_req(16'h0305, 2'd0, 0, 0, 1'b0);

        // partially valid line, table says way 0
        do_req(16'h0007, 2'd0, 0, 0, 1'b0);
        do_req(16'h0087, 2'd1, 0, 0, 1'b0);
        do_req(16'h0107, 2'd0, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            int          sel;
            sel = int'($urandom_range(0, 2));
            a[6:0]  = (sel == 0) ? 7'd2 : (sel == 1) ? 7'd5 : 7'd9;
            a[15:7] = 9'($urandom_range(0, 6));
            do_req(a, 2'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        chk("final_idle", 32'(bus.req_ready), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
